// File: rtl/sram_like_bridge.sv
// ============================================================================
//  Module   : sram_like_bridge
//  Purpose  : Turns a single-cycle SRAM-style core port into an SRAM-like
//             split transaction. The address phase uses req/addr_ok and the
//             data phase uses data_ok. The pipeline is stalled until the
//             transaction completes. Read data stays buffered so that the
//             stage after the requester can consume it once the pipeline
//             resumes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W   width of the address and data buses (default 32)
//    TIMEOUT  REQ+WAIT cycle limit for the sticky err flag; 0 = no watchdog
//  Build option
//    SRAM_LIKE_ADDR_MAP_EN  when defined, kseg0/kseg1 addresses (top three
//                           bits 100/101) are folded to physical addresses
//                           by clearing the top three bits
//  Ports
//    clk, rst        clock (rising edge), synchronous active-low reset
//    core_en         core access request, held while stallreq=1
//    core_wen        byte write enables, 0 = read
//    core_addr       byte address
//    core_wdata      store data
//    core_rdata      buffered read data
//    stall_hold      core stage is stalled by another source
//    stallreq        pipeline stall request
//    req, wr, size   bus address-phase request, write flag, transfer size
//    addr, wdata     latched bus address and write data
//    addr_ok         address phase accepted
//    data_ok         data phase complete, bus_rdata valid
//    bus_rdata       bus read data
//    err             sticky watchdog timeout flag
// ============================================================================
`default_nettype none

module sram_like_bridge #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_en,
  input  logic [3:0]        core_wen,
  input  logic [DATA_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              stall_hold,
  output logic              stallreq,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q;
  logic [1:0]        state_d;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        size_dec;
  logic [DATA_W-1:0] addr_map;
  logic              launch;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (core_en)     state_d = S_REQ;
      S_REQ:   if (addr_ok)     state_d = S_WAIT;   // early data_ok ignored
      S_WAIT:  if (data_ok)     state_d = S_DONE;
      // Staying in DONE while the core is held prevents re-issuing the
      // request that core_en still presents.
      S_DONE:  if (!stall_hold) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req      = 1'b0;
    stallreq = 1'b0;
    case (state_q)
      S_IDLE:  stallreq = core_en;
      S_REQ: begin
        req      = 1'b1;
        stallreq = 1'b1;
      end
      S_WAIT:  stallreq = 1'b1;
      default: stallreq = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  // Only naturally aligned single-byte and half-word enables narrow the
  // transfer. Every other pattern is treated as a full word.
  always_comb begin
    case (core_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_dec = 2'd0;
      4'b0011, 4'b1100:                   size_dec = 2'd1;
      default:                            size_dec = 2'd2;
    endcase
  end

`ifdef SRAM_LIKE_ADDR_MAP_EN
  always_comb begin
    addr_map = core_addr;
    if ((core_addr[DATA_W-1 -: 3] == 3'b100) ||
        (core_addr[DATA_W-1 -: 3] == 3'b101)) begin
      addr_map = {3'b000, core_addr[DATA_W-4:0]};
    end
  end
`else
  assign addr_map = core_addr;
`endif

  assign launch = (state_q == S_IDLE) && core_en;

  // --------------------------------------------------------------------------
  // Latched bus fields and read buffer
  // --------------------------------------------------------------------------
  // The bus fields are loaded only on launch, so they stay stable from REQ
  // until the DONE exit. The read buffer changes only on a read completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (launch) begin
        wr_q    <= |core_wen;
        size_q  <= size_dec;
        addr_q  <= addr_map;
        wdata_q <= core_wdata;
      end
      if ((state_q == S_WAIT) && data_ok && !wr_q) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  assign wr         = wr_q;
  assign size       = size_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign core_rdata = rdata_q;

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int              CNT_W     = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             err_q;
      logic             err_d;

      // The counter saturates at the limit. The FSM keeps waiting, so only
      // the flag reports the stuck transaction.
      always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
          if (cnt_q != C_TIMEOUT) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_d == C_TIMEOUT) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          err_q <= err_d;
        end
      end

      assign err = err_q;
    end else begin : g_no_wdog
      assign err = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sram_like_bridge.sv
// ============================================================================
//  Module   : tb_sram_like_bridge
//  Purpose  : Self-checking bench for sram_like_bridge. Expected read data is
//             queued when a transaction is issued and compared when the
//             bridge reaches DONE.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_like_bridge;

  localparam int C_TO = 4;

  logic        clk;
  logic        rst;
  logic        core_en;
  logic [3:0]  core_wen;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        stall_hold;
  logic        stallreq;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] bus_rdata;
  logic        err;

  int          total;
  int          bad;
  logic [31:0] rd_model;
  logic        err_exp;
  logic [31:0] sb[$];

  sram_like_bridge #(.DATA_W(32), .TIMEOUT(C_TO)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .core_en    (core_en),
    .core_wen   (core_wen),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .stall_hold (stall_hold),
    .stallreq   (stallreq),
    .req        (req),
    .wr         (wr),
    .size       (size),
    .addr       (addr),
    .wdata      (wdata),
    .addr_ok    (addr_ok),
    .data_ok    (data_ok),
    .bus_rdata  (bus_rdata),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    core_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    rd_model = 32'h0;
    err_exp = 1'b0;
    check("rst_req", {31'b0, req}, 32'h0);
    check("rst_wr", {31'b0, wr}, 32'h0);
    check("rst_size", {30'b0, size}, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_stall", {31'b0, stallreq}, 32'h0);
  endtask

  // Runs one transaction starting in IDLE and ends back in IDLE.
  // adly: REQ cycles without addr_ok, ddly: extra WAIT cycles before data_ok.
  task automatic do_txn(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ea, input logic [1:0] es,
                        input int adly, input int ddly, input logic [31:0] brd, input int hold);
    logic [31:0] exp_rd;
    int          busy;
    // IDLE: the previous read result must still be available
    check("idle_req", {31'b0, req}, 32'h0);
    check("idle_rdata", core_rdata, rd_model);
    core_en    = 1'b1;
    core_wen   = wen;
    core_addr  = a;
    core_wdata = wd;
    #1;
    check("idle_stall", {31'b0, stallreq}, 32'h1);
    if (wen == 4'b0000) rd_model = brd;
    sb.push_back(rd_model);
    tick();
    // REQ
    for (int i = 0; i < adly; i++) begin
      check("req_hold", {31'b0, req}, 32'h1);
      tick();
    end
    check("req_req", {31'b0, req}, 32'h1);
    check("req_stall", {31'b0, stallreq}, 32'h1);
    check("req_wr", {31'b0, wr}, {31'b0, |wen});
    check("req_size", {30'b0, size}, {30'b0, es});
    check("req_addr", addr, ea);
    check("req_wdata", wdata, wd);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    // WAIT
    check("wait_req", {31'b0, req}, 32'h0);
    check("wait_stall", {31'b0, stallreq}, 32'h1);
    for (int i = 0; i < ddly; i++) begin
      tick();
      check("wait_stall2", {31'b0, stallreq}, 32'h1);
    end
    data_ok   = 1'b1;
    bus_rdata = brd;
    tick();
    data_ok   = 1'b0;
    bus_rdata = 32'h0BAD0BAD;
    busy = adly + 1 + ddly + 1;
    if (busy >= C_TO) err_exp = 1'b1;
    // DONE
    check("done_stall", {31'b0, stallreq}, 32'h0);
    check("done_req", {31'b0, req}, 32'h0);
    check("done_addr", addr, ea);
    check("done_err", {31'b0, err}, {31'b0, err_exp});
    if (sb.size() == 0) begin
      check("sb_empty", 32'h1, 32'h0);
    end else begin
      exp_rd = sb.pop_front();
      check("done_rdata", core_rdata, exp_rd);
    end
    if (hold > 0) begin
      stall_hold = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_stall", {31'b0, stallreq}, 32'h0);
        check("hold_req", {31'b0, req}, 32'h0);
      end
      stall_hold = 1'b0;
      tick();
      // back in IDLE with core_en still presented
      check("post_hold_stall", {31'b0, stallreq}, 32'h1);
      core_en = 1'b0;
    end else begin
      core_en = 1'b0;
      tick();
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    core_en    = 1'b0;
    core_wen   = 4'h0;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    stall_hold = 1'b0;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    bus_rdata  = 32'h0;
    rd_model   = 32'h0;
    err_exp    = 1'b0;

    do_reset();

    // short read, then the reference read with data two cycles after addr_ok
    do_txn(4'b0000, 32'h0000_0100, 32'h0, 32'h0000_0100, 2'd2, 0, 0, 32'h1111_2222, 0);
    do_txn(4'b0000, 32'h0000_1000, 32'h0, 32'h0000_1000, 2'd2, 0, 1, 32'hDEAD_BEEF, 0);
    tick();
    check("rd_held1", core_rdata, 32'hDEAD_BEEF);
    tick();
    check("rd_held2", core_rdata, 32'hDEAD_BEEF);

    // byte store with addr_ok delayed 3 cycles (long enough to trip watchdog)
    do_txn(4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h0000_2002, 2'd0, 3, 0, 32'hFFFF_0000, 0);
    // halfword store, then back-to-back read with stall_hold in DONE
    do_txn(4'b1100, 32'h0000_3000, 32'h1234_5678, 32'h0000_3000, 2'd1, 0, 0, 32'hFFFF_1111, 0);
    do_txn(4'b0000, 32'h0000_4000, 32'h0, 32'h0000_4000, 2'd1 + 2'd1, 1, 0, 32'hCAFE_F00D, 2);
    // irregular and full-word enables
    do_txn(4'b0101, 32'h0000_5000, 32'hA5A5_A5A5, 32'h0000_5000, 2'd2, 0, 0, 32'hFFFF_2222, 0);
    do_txn(4'b1111, 32'h0000_6000, 32'h5A5A_5A5A, 32'h0000_6000, 2'd2, 0, 0, 32'hFFFF_3333, 0);
    do_txn(4'b0001, 32'h0000_6001, 32'h0000_00EE, 32'h0000_6001, 2'd0, 0, 0, 32'hFFFF_4444, 0);

    // address mapping
`ifdef SRAM_LIKE_ADDR_MAP_EN
    do_txn(4'b0000, 32'hBFC0_0000, 32'h0, 32'h1FC0_0000, 2'd2, 0, 0, 32'h0101_0101, 0);
    do_txn(4'b0000, 32'h9FC0_0010, 32'h0, 32'h1FC0_0010, 2'd2, 0, 0, 32'h0202_0202, 0);
`else
    do_txn(4'b0000, 32'hBFC0_0000, 32'h0, 32'hBFC0_0000, 2'd2, 0, 0, 32'h0101_0101, 0);
    do_txn(4'b0000, 32'h9FC0_0010, 32'h0, 32'h9FC0_0010, 2'd2, 0, 0, 32'h0202_0202, 0);
`endif

    // watchdog: addr_ok never arrives
    do_reset();
    core_en   = 1'b1;
    core_wen  = 4'b0000;
    core_addr = 32'h0000_7000;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("wd_req", {31'b0, req}, 32'h1);
      check("wd_err", {31'b0, err}, (k >= C_TO) ? 32'h1 : 32'h0);
    end

    // reset mid-transaction
    rst     = 1'b0;
    core_en = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_req", {31'b0, req}, 32'h0);
    check("mid_rst_err", {31'b0, err}, 32'h0);
    check("mid_rst_stall", {31'b0, stallreq}, 32'h0);
    check("mid_rst_rdata", core_rdata, 32'h0);
    data_ok   = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick();
    data_ok = 1'b0;
    check("stray_rdata", core_rdata, 32'h0);
    check("stray_stall", {31'b0, stallreq}, 32'h0);
    tick();
    check("stray_req", {31'b0, req}, 32'h0);
    check("stray_rdata2", core_rdata, 32'h0);
    check("sb_drained", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Converts one single-cycle SRAM-style core port (instruction or data side) into an SRAM-like split handshake: req/addr_ok for the address phase, data_ok for the data phase.
- Sits directly downstream of mycpu_core, with one instance per port, between the core and the bus/cache interconnect.
- Raises a stall request to the pipeline controller until the transaction completes.
- Holds read data stable for the consuming stage after the pipeline resumes.

Parameters:
- DATA_W, 32, width of address and data buses.
- TIMEOUT, 0, maximum cycles allowed in REQ+WAIT before the sticky error sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low; rst==0 at a rising clk edge resets the block.
- core_en  in  1  core access request; held constant by the core while stallreq=1.
- core_wen  in  4  byte write enables; 0 means read.
- core_addr  in  DATA_W  byte address.
- core_wdata  in  DATA_W  store data.
- core_rdata  out  DATA_W  read data buffer.
- stall_hold  in  1  core stage stalled by another source.
- stallreq  out  1  pipeline stall request.
- req  out  1  bus address-phase request.
- wr  out  1  1 = write.
- size  out  2  0 = byte, 1 = half, 2 = word.
- addr  out  DATA_W  bus address.
- wdata  out  DATA_W  bus write data.
- addr_ok  in  1  address phase accepted.
- data_ok  in  1  data phase complete.
- bus_rdata  in  DATA_W  read data, valid with data_ok.
- err  out  1  sticky watchdog timeout flag.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset: state=IDLE, all outputs 0 (req, wr, size, addr, wdata, core_rdata, err, watchdog counter).
- IDLE:
  - stallreq = core_en (combinational).
  - If core_en=1: latch wr=|core_wen, size, addr=core_addr, wdata=core_wdata; next state REQ.
  - A data_ok seen in IDLE is ignored.
- REQ:
  - req=1, stallreq=1.
  - addr_ok=1 leads to WAIT on the next cycle, with req=0 in WAIT.
  - data_ok in REQ is a protocol violation and is ignored.
- WAIT:
  - stallreq=1.
  - data_ok=1: capture bus_rdata into core_rdata on reads only (writes leave core_rdata unchanged); next state DONE.
- DONE:
  - stallreq=0. The core advances at this edge unless stall_hold=1.
  - stall_hold=1 keeps the state in DONE, so no re-issue of the still-asserted core_en.
  - stall_hold=0 leads to IDLE.
- core_rdata is held until the next read data_ok, so the stage after the requester can consume it the cycle after DONE.
- size encoding from core_wen:
  - 0001/0010/0100/1000 give size 0.
  - 0011/1100 give size 1.
  - 1111 or 0000 give size 2.
  - Any other pattern gives size 2, and wr follows |core_wen.
- Latched bus fields stay constant from REQ until DONE exit.
- Minimum latency: the IDLE request cycle, then REQ with addr_ok, then WAIT with data_ok, then DONE. That gives 4 cycles from core_en to stallreq low.
- Watchdog (TIMEOUT>0):
  - The counter increments each cycle in REQ/WAIT and clears in IDLE/DONE.
  - When the counter reaches TIMEOUT, err sets and stays set until reset. The FSM keeps waiting.
- Reset mid-transaction: state returns to IDLE, req drops the same edge, and the buffer clears. A later stray data_ok is ignored.

Optional Feature:
- Macro: SRAM_LIKE_ADDR_MAP_EN.
- Defined: MIPS fixed mapping on the latched addr.
  - core_addr[31:29] of 3'b100 (kseg0) or 3'b101 (kseg1) gives addr = {3'b000, core_addr[28:0]}.
  - All other addresses pass unchanged.
- Undefined: addr = core_addr verbatim.

Test Plan:
- Read: core_en=1, wen=0, core_addr=0x00001000; addr_ok at REQ cycle 1; data_ok with bus_rdata=0xDEADBEEF 2 cycles later -> req high exactly 1 cycle; wr=0, size=2; stallreq low in DONE; core_rdata=0xDEADBEEF held through the following IDLE cycles.
- Byte store: wen=0100, addr=0x00002002, wdata=0x00AB0000 -> wr=1, size=0, addr=0x00002002; addr_ok delayed 3 cycles -> req held 4 cycles; core_rdata unchanged after data_ok.
- Halfword store wen=1100 -> size=1. Back-to-back: next core_en asserted the cycle after DONE -> new REQ starts; previous core_rdata still valid that cycle.
- stall_hold=1 for 2 cycles in DONE -> state stays DONE; no second req despite core_en=1; returns to IDLE when stall_hold=0.
- TIMEOUT=4, addr_ok never asserted -> err=1 after 4 REQ cycles and stays 1. Then rst=0 for 1 cycle -> err=0, req=0, state IDLE; a stray data_ok afterwards causes no change.
- With SRAM_LIKE_ADDR_MAP_EN: core_addr=0xBFC00000 -> addr=0x1FC00000; core_addr=0x9FC00010 -> addr=0x1FC00010. Without it: addr=0xBFC00000.
